pixel_scanner: RTL and testbench

Raster sweep engine sitting directly upstream of the output generator. On each frame request it walks every pixel of the 160x120 playfield, driving X/Y into the output generator. It also delays those coordinates to line up with the generator's color pipeline, producing the coordinate and plot strobe that the VGA adapter consumes. At the end of each frame it pulses `done`, so game logic can update Pacman, ghost and coin state between frames without tearing.

---
 rtl/pixel_scanner.sv | 163 ++++++++++++++++
 tb/tb_pixel_scanner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scanner.sv
// pixel_scanner: raster sweep engine for the 160x120 playfield.
//
// On a frame request it walks every pixel once, driving X/Y to the output
// generator, and delays the coordinates by LATENCY cycles so that vga_x,
// vga_y and plot line up with the generator's color output. done pulses
// once per frame so game logic can update state between frames.
//
// Ports:
//   clock    in   rising-edge clock
//   resetn   in   asynchronous active-low reset
//   start    in   frame request, only honoured in IDLE
//   X, Y     out  current scan coordinate (to output generator)
//   vga_x/y  out  coordinate delayed by LATENCY (to VGA adapter)
//   plot     out  VGA write enable, aligned with vga_x/vga_y/color
//   busy     out  frame in progress (scan + drain)
//   done     out  one-cycle end-of-frame pulse
//   overrun  out  sticky: internal frame tick arrived while busy
//
// Optional feature: define PIXEL_SCANNER_FRAME_TICK_EN to add a free-running
// FRAME_CYCLES counter whose wrap tick also starts frames. Without it,
// frames start only from start and overrun is tied low.
//
// All outputs are registered. The state machine runs one cycle ahead of
// X/Y/busy/done, so a start sampled at edge 0 shows pixel 0 after edge 1.
module pixel_scanner #(
    parameter int WIDTH        = 160,
    parameter int HEIGHT       = 120,
    parameter int LATENCY      = 2,
    parameter int FRAME_CYCLES = 833334
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    output logic [7:0] X,
    output logic [6:0] Y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam logic [7:0] XMAX = 8'(WIDTH - 1);
    localparam logic [6:0] YMAX = 7'(HEIGHT - 1);
    localparam int         DW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [DW-1:0] DMAX = DW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [7:0]    x_cnt;
    logic [6:0]    y_cnt;
    logic [DW-1:0] drain_cnt;
    logic          req;
    logic          last_pix;

    // vld_pipe[0] is aligned with X/Y; vld_pipe[LATENCY] drives plot.
    logic [LATENCY:0]        vld_pipe;
    logic [LATENCY-1:0][7:0] xp;
    logic [LATENCY-1:0][6:0] yp;

`ifdef PIXEL_SCANNER_FRAME_TICK_EN
    localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    logic [FW-1:0] fcnt;
    logic          tick;

    assign tick = (fcnt == FW'(FRAME_CYCLES - 1));
    assign req  = start | tick;

    // Free-running frame timer, independent of the scan.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fcnt    <= '0;
            overrun <= 1'b0;
        end else begin
            fcnt <= tick ? '0 : fcnt + 1'b1;
            if (tick && state != IDLE)
                overrun <= 1'b1;
        end
    end
`else
    logic unused_frame;

    assign req          = start;
    assign overrun      = 1'b0;
    assign unused_frame = (FRAME_CYCLES != 0);
`endif

    assign last_pix = (state == SCAN) && (x_cnt == XMAX) && (y_cnt == YMAX);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = SCAN;
            SCAN:    if (last_pix) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DMAX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Raster counters; they wrap to 0 after the last pixel, so DRAIN
    // and IDLE naturally see X=Y=0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == SCAN) begin
                if (x_cnt == XMAX) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == YMAX) ? 7'd0 : y_cnt + 7'd1;
                end else begin
                    x_cnt <= x_cnt + 8'd1;
                end
            end else begin
                x_cnt <= '0;
                y_cnt <= '0;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    // Registered outputs plus the coordinate/valid delay line.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            X        <= '0;
            Y        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            vld_pipe <= '0;
            xp       <= '0;
            yp       <= '0;
        end else begin
            X           <= (state == SCAN) ? x_cnt : 8'd0;
            Y           <= (state == SCAN) ? y_cnt : 7'd0;
            busy        <= (state == SCAN) || (state == DRAIN);
            done        <= (state == DONE);
            vld_pipe[0] <= (state == SCAN);
            xp[0]       <= X;
            yp[0]       <= Y;
            for (int i = 1; i <= LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            for (int i = 1; i < LATENCY; i++) begin
                xp[i] <= xp[i-1];
                yp[i] <= yp[i-1];
            end
        end
    end

    assign plot  = vld_pipe[LATENCY];
    assign vga_x = xp[LATENCY-1];
    assign vga_y = yp[LATENCY-1];

endmodule

// File: tb/tb_pixel_scanner.sv
// Directed testbench for pixel_scanner (default build, no frame tick).
// Edge 0 is the rising edge that samples start; "after edge e" values
// are sampled on the following falling edge.
module tb_pixel_scanner;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int L    = 2;
    localparam int NPIX = W * H;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] X, vga_x;
    logic [6:0] Y, vga_y;
    logic       plot, busy, done, overrun;

    int tests = 0;
    int fails = 0;

    pixel_scanner #(.WIDTH(W), .HEIGHT(H), .LATENCY(L)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .X(X), .Y(Y), .vga_x(vga_x), .vga_y(vga_y),
        .plot(plot), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Output generator model: ROM read + output register = 2-cycle color.
    function automatic logic [7:0] colr(input logic [7:0] x, input logic [6:0] y);
        return (x ^ {y, 1'b1}) + 8'h5a;
    endfunction

    logic [7:0] c1, c2;
    always @(posedge clock) begin
        c1 <= colr(X, Y);
        c2 <= c1;
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Request a frame: start high across edge 0, sampled after edge 0.
    task automatic kick(input bit hold);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset();
        logic [33:0] outs;
        resetn = 1'b0;
        #2;
        outs = {X, Y, vga_x, vga_y, plot, busy, done, overrun};
        tests++;
        if (outs !== 34'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        @(negedge clock);
        resetn = 1'b1;
        repeat (5) step();
        outs = {X, Y, vga_x, vga_y, plot, busy, done, overrun};
        tests++;
        if (outs !== 34'd0) begin
            fails++;
            $display("FAIL idle_after_reset: got %h want 0", outs);
        end
    endtask

    // Full frame, with stray start pulses mid-scan that must be ignored.
    task automatic test_single_frame();
        int xy_err = 0, busy_err = 0, plot_err = 0, vga_err = 0, col_err = 0;
        int done_err = 0, nplot = 0, first_bad = -1, k;
        logic [7:0] ex;
        logic [6:0] ey;
        kick(1'b0);
        for (int e = 1; e <= NPIX + 10; e++) begin
            step();
            k  = e - 1;
            ex = (e >= 1 && e <= NPIX) ? 8'(k % W) : 8'd0;
            ey = (e >= 1 && e <= NPIX) ? 7'(k / W) : 7'd0;
            if (X !== ex || Y !== ey) begin
                xy_err++;
                if (first_bad < 0) first_bad = e;
            end
            if (busy !== (e >= 1 && e <= NPIX + L)) busy_err++;
            if (plot !== (e >= 1 + L && e <= NPIX + L)) plot_err++;
            if (done !== (e == NPIX + L + 1)) done_err++;
            if (plot === 1'b1) begin
                nplot++;
                k = e - 1 - L;
                if (vga_x !== 8'(k % W) || vga_y !== 7'(k / W)) vga_err++;
                if (c2 !== colr(vga_x, vga_y)) col_err++;
            end
            if (e == 1 + L) begin
                tests++;
                if (vga_x !== 8'd0 || vga_y !== 7'd0 || plot !== 1'b1) begin
                    fails++;
                    $display("FAIL first_plot: got x=%0d y=%0d plot=%b want 0 0 1", vga_x, vga_y, plot);
                end
            end
            if (e == NPIX + L) begin
                tests++;
                if (vga_x !== 8'd159 || vga_y !== 7'd119 || plot !== 1'b1) begin
                    fails++;
                    $display("FAIL last_plot: got x=%0d y=%0d plot=%b want 159 119 1", vga_x, vga_y, plot);
                end
            end
            if (e == NPIX + L + 1) begin
                tests++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL done_edge: got done=%b busy=%b at edge %0d want 1 0", done, busy, e);
                end
            end
            start = (e == 100 || e == 9000 || e == 19000);
        end
        tests++;
        if (xy_err !== 0) begin
            fails++;
            $display("FAIL scan_xy: %0d bad cycles (first edge %0d) want 0", xy_err, first_bad);
        end
        tests++;
        if (busy_err !== 0) begin
            fails++;
            $display("FAIL busy_window: %0d bad cycles want 0", busy_err);
        end
        tests++;
        if (plot_err !== 0 || nplot !== NPIX) begin
            fails++;
            $display("FAIL plot_window: %0d bad cycles, %0d plots want 0, %0d", plot_err, nplot, NPIX);
        end
        tests++;
        if (vga_err !== 0) begin
            fails++;
            $display("FAIL vga_coords: %0d bad plots want 0", vga_err);
        end
        tests++;
        if (col_err !== 0) begin
            fails++;
            $display("FAIL color_align: %0d bad plots want 0", col_err);
        end
        tests++;
        if (done_err !== 0) begin
            fails++;
            $display("FAIL done_pulse: %0d bad cycles want 0", done_err);
        end
    endtask

    task automatic test_row_boundary();
        logic [29:0] got;
        kick(1'b0);
        for (int e = 1; e <= W + 3; e++) begin
            step();
            got = {X, Y, vga_x, vga_y};
            if (e == W) begin
                tests++;
                if ({X, Y} !== {8'd159, 7'd0}) begin
                    fails++;
                    $display("FAIL row_end_xy: got X=%0d Y=%0d want 159 0", X, Y);
                end
            end
            if (e == W + 1) begin
                tests++;
                if ({X, Y} !== {8'd0, 7'd1}) begin
                    fails++;
                    $display("FAIL row_wrap_xy: got X=%0d Y=%0d want 0 1", X, Y);
                end
            end
            if (e == W + L) begin
                tests++;
                if ({vga_x, vga_y, plot} !== {8'd159, 7'd0, 1'b1}) begin
                    fails++;
                    $display("FAIL row_end_vga: got %h want x=159 y=0 plot=1", got);
                end
            end
            if (e == W + L + 1) begin
                tests++;
                if ({vga_x, vga_y, plot} !== {8'd0, 7'd1, 1'b1}) begin
                    fails++;
                    $display("FAIL row_wrap_vga: got %h want x=0 y=1 plot=1", got);
                end
            end
        end
        @(negedge clock);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    // start held high: frames repeat with done every NPIX+L+2 cycles.
    task automatic test_back_to_back();
        int d1 = -1, d2 = -1, nd = 0, np = 0, tail_err = 0;
        int last_e = 2 * (NPIX + L + 2) - 1;
        kick(1'b1);
        for (int e = 1; e <= last_e; e++) begin
            step();
            if (done === 1'b1) begin
                nd++;
                if (d1 < 0) d1 = e;
                else if (d2 < 0) d2 = e;
            end
            if (plot === 1'b1) np++;
            if (e == last_e) start = 1'b0;
        end
        for (int e = 0; e < 8; e++) begin
            step();
            if (busy !== 1'b0 || plot !== 1'b0 || done !== 1'b0) tail_err++;
        end
        tests++;
        if (d1 !== NPIX + L + 1) begin
            fails++;
            $display("FAIL b2b_first_done: got edge %0d want %0d", d1, NPIX + L + 1);
        end
        tests++;
        if (d2 - d1 !== NPIX + L + 2) begin
            fails++;
            $display("FAIL b2b_period: got %0d want %0d", d2 - d1, NPIX + L + 2);
        end
        tests++;
        if (nd !== 2 || np !== 2 * NPIX) begin
            fails++;
            $display("FAIL b2b_counts: got done=%0d plots=%0d want 2 %0d", nd, np, 2 * NPIX);
        end
        tests++;
        if (tail_err !== 0) begin
            fails++;
            $display("FAIL b2b_stop: %0d active cycles after start dropped want 0", tail_err);
        end
    endtask

    task automatic test_reset_abort();
        logic [33:0] outs;
        int act = 0, xy_nz = 0;
        kick(1'b0);
        for (int e = 1; e <= 5001; e++) step();
        tests++;
        if (busy !== 1'b1 || plot !== 1'b1) begin
            fails++;
            $display("FAIL abort_precheck: got busy=%b plot=%b want 1 1", busy, plot);
        end
        #2;
        resetn = 1'b0;
        #1;
        outs = {X, Y, vga_x, vga_y, plot, busy, done, overrun};
        tests++;
        if (outs !== 34'd0) begin
            fails++;
            $display("FAIL abort_async_clear: got %h want 0", outs);
        end
        step();
        resetn = 1'b1;
        for (int e = 0; e < 200; e++) begin
            step();
            if (busy !== 1'b0 || plot !== 1'b0 || done !== 1'b0) act++;
            if (X !== 8'd0 || Y !== 7'd0) xy_nz++;
        end
        tests++;
        if (act !== 0 || xy_nz !== 0) begin
            fails++;
            $display("FAIL abort_stays_idle: got %0d active, %0d nonzero XY cycles want 0 0", act, xy_nz);
        end
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_tied: got %b want 0", overrun);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_row_boundary();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
